// File: rtl/custom_load_scheduler.sv
// Layer-pass sequencer: per tile runs loader clear/load, a settle cycle, PE compute,
// then result drain; repeats for NUM_TILES tiles between host start and done.
module custom_load_scheduler #(
    parameter int unsigned NUM_TILES      = 4,
    parameter int unsigned COMPUTE_CYCLES = 8,
    parameter int unsigned DRAIN_BEATS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       loader_done_i,
    input  logic       out_ready_i,
    output logic       loader_clr_o,
    output logic       loader_en_o,
    output logic       pe_en_o,
    output logic       out_valid_o,
    output logic [7:0] tile_idx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        IDLE, CLR, LOAD, SETTLE, COMPUTE, DRAIN, DONE, ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [CW-1:0] tile_q, tile_d;

    // State and counter registers; outputs are registered decodes of the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            beat_q       <= '0;
            tile_q       <= '0;
            loader_clr_o <= 1'b0;
            loader_en_o  <= 1'b0;
            pe_en_o      <= 1'b0;
            out_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            tile_q       <= tile_d;
            loader_clr_o <= (state_d == CLR) || (state_d == ABORT);
            loader_en_o  <= (state_d == LOAD);
            pe_en_o      <= (state_d == COMPUTE);
            out_valid_o  <= (state_d == DRAIN);
            busy_o       <= (state_d != IDLE);
            done_o       <= (state_d == DONE);
        end
    end

    assign tile_idx_o = tile_q;

    // Next-state and counter update; abort overrides every non-idle transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        tile_d  = tile_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLR;
                    tile_d  = '0;
                end
            end
            CLR:    state_d = LOAD;
            LOAD:   if (loader_done_i) state_d = SETTLE;
            SETTLE: begin
                cnt_d   = '0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(COMPUTE_CYCLES - 1)) begin
                    state_d = DRAIN;
                    beat_d  = '0;
                end
            end
            DRAIN: begin
                if (out_ready_i) begin
                    beat_d = beat_q + CW'(1);
                    if (beat_q == CW'(DRAIN_BEATS - 1)) begin
                        if (tile_q == CW'(NUM_TILES - 1)) begin
                            state_d = DONE;
                        end else begin
                            tile_d  = tile_q + CW'(1);
                            state_d = CLR;
                        end
                    end
                end
            end
            DONE:  state_d = IDLE;
            ABORT: begin
                state_d = IDLE;
                tile_d  = '0;
                cnt_d   = '0;
                beat_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        if (abort_i && (state_q inside {CLR, LOAD, SETTLE, COMPUTE, DRAIN}))
            state_d = ABORT;
    end

endmodule

// File: tb/tb_custom_load_scheduler.sv
// Directed bench for custom_load_scheduler with a simple loader model and activity monitors.
module tb_custom_load_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, abort_i, loader_done_i, out_ready_i;
    logic       loader_clr_o, loader_en_o, pe_en_o, out_valid_o, busy_o, done_o;
    logic [7:0] tile_idx_o;

    int total = 0;
    int bad   = 0;

    custom_load_scheduler #(
        .NUM_TILES(3), .COMPUTE_CYCLES(4), .DRAIN_BEATS(4)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .loader_done_i(loader_done_i), .out_ready_i(out_ready_i),
        .loader_clr_o(loader_clr_o), .loader_en_o(loader_en_o), .pe_en_o(pe_en_o),
        .out_valid_o(out_valid_o), .tile_idx_o(tile_idx_o), .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Loader model: done once it has seen ld_target+1 enable cycles since the last clear
    int ld_cnt = 0;
    int ld_target = 0;
    always @(posedge clk) begin
        if (loader_clr_o) ld_cnt <= 0;
        else if (loader_en_o) ld_cnt <= ld_cnt + 1;
    end
    assign loader_done_i = (ld_cnt >= ld_target);

    // Cumulative activity monitors, sampled on the active edge (pre-update values)
    int cyc = 0, clr_n = 0, en_n = 0, pe_n = 0, beat_n = 0, done_n = 0, b2b_n = 0, done_cyc = 0;
    logic prev_valid = 1'b0;
    int tile_log[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_valid <= out_valid_o;
        if (loader_clr_o) clr_n <= clr_n + 1;
        if (loader_clr_o && busy_o && !abort_i) tile_log.push_back(int'(tile_idx_o));
        if (loader_clr_o && prev_valid) b2b_n <= b2b_n + 1;
        if (loader_en_o) en_n <= en_n + 1;
        if (pe_en_o) pe_n <= pe_n + 1;
        if (out_valid_o && out_ready_i) beat_n <= beat_n + 1;
        if (done_o) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int outs_word();
        return int'({loader_clr_o, loader_en_o, pe_en_o, out_valid_o, busy_o, done_o, tile_idx_o});
    endfunction

    task automatic wait_done(input int base_done, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_n > base_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    int  s, b_clr, b_en, b_pe, b_beat, b_done, b_b2b, vcount;
    bit  seen;

    initial begin
        rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; out_ready_i = 1'b1;
        ld_target = 4;
        #12;
        check("reset_outputs", outs_word(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", outs_word(), 0);

        // Full 3-tile pass, 5 loader cycles per tile, no stalls
        tile_log.delete();
        b_clr = clr_n; b_en = en_n; b_pe = pe_n; b_beat = beat_n; b_done = done_n; b_b2b = b2b_n;
        abort_i = 1'b1;
        @(negedge clk);
        check("abort_ignored_idle", int'(busy_o), 0);
        abort_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        s = cyc;
        check("start_clr_n1", int'(loader_clr_o), 1);
        @(negedge clk);
        check("start_en_n2", int'(loader_en_o), 1);
        wait_done(b_done, 200, seen);
        check("pass_done_seen", int'(seen), 1);
        check("pass_done_time", done_cyc - s, 45);
        check("pass_clr_pulses", clr_n - b_clr, 3);
        check("pass_en_cycles", en_n - b_en, 15);
        check("pass_pe_cycles", pe_n - b_pe, 12);
        check("pass_beats", beat_n - b_beat, 12);
        check("pass_b2b_tiles", b2b_n - b_b2b, 2);
        check("pass_tile_seq_len", tile_log.size(), 3);
        for (int i = 0; i < tile_log.size(); i++) check("pass_tile_seq", tile_log[i], i);
        check("done_holds_tile", int'(tile_idx_o), 2);
        @(negedge clk);
        check("done_pulse_once", done_n - b_done, 1);
        check("idle_after_done", int'(busy_o), 0);

        // Backpressure: loader done on first LOAD cycle, ready low 5 cycles mid-drain
        ld_target = 0;
        b_beat = beat_n; b_done = done_n; b_en = en_n;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        s = cyc;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid_o && (beat_n - b_beat) == 2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_reach_drain", int'(seen), 1);
        out_ready_i = 1'b0;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid_o) vcount++;
        end
        check("bp_valid_held", vcount, 5);
        check("bp_beats_frozen", beat_n - b_beat, 2);
        out_ready_i = 1'b1;
        wait_done(b_done, 200, seen);
        check("bp_done_seen", int'(seen), 1);
        check("bp_done_time", done_cyc - s, 38);
        check("bp_beats_total", beat_n - b_beat, 12);
        check("bp_load_one_cycle", en_n - b_en, 3);
        @(negedge clk);

        // Abort during COMPUTE of tile 1
        ld_target = 2;
        b_done = done_n;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (pe_en_o && tile_idx_o == 8'd1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reach_compute1", int'(seen), 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_clr", int'(loader_clr_o), 1);
        check("abort_pe_off", int'(pe_en_o), 0);
        check("abort_busy", int'(busy_o), 1);
        @(negedge clk);
        check("abort_idle", int'(busy_o), 0);
        check("abort_tile_cleared", int'(tile_idx_o), 0);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_n - b_done, 0);

        // Start pulse while busy in LOAD must not disturb the pass
        ld_target = 4;
        b_clr = clr_n; b_done = done_n;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        s = cyc;
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(b_done, 200, seen);
        check("busy_start_done_time", done_cyc - s, 45);
        check("busy_start_clr", clr_n - b_clr, 3);
        @(negedge clk);

        // Asynchronous reset mid-LOAD
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_load", int'(loader_en_o), 1);
        #2 rst = 1'b0;
        #1 check("rst_async_outputs", outs_word(), 0);
        @(negedge clk);
        rst = 1'b1;
        b_clr = clr_n;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", outs_word(), 0);
        check("rst_no_clr", clr_n - b_clr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
